// File: rtl/chirp_sweep_gen.sv
// Chirp sweep generator: register-configured linear-FM phase accumulator that
// emits phase MSBs as a sawtooth sample stream, with up/down/alternating sweeps.
module chirp_sweep_gen #(
  parameter int PHASE_WIDTH      = 32,
  parameter int OUT_WIDTH        = 8,
  parameter int MAX_SF           = 12,
  parameter int DIVIDER_BITWIDTH = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_we,
  input  logic [3:0]           i_cfg_addr,
  input  logic [7:0]           i_cfg_data,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_done_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SF_MIN = 4'd5;
  localparam logic [3:0] SF_MAX = 4'(MAX_SF);

  state_t                      state;
  logic [1:0]                  mode_q;
  logic [3:0]                  sf_q;
  logic [DIVIDER_BITWIDTH-1:0] div_q;
  logic [7:0]                  nsym_q;
  logic [31:0]                 f_start_q;
  logic [31:0]                 f_step_q;

  logic [PHASE_WIDTH-1:0]      phase_q;
  logic [PHASE_WIDTH-1:0]      freq_q;
  logic [DIVIDER_BITWIDTH-1:0] div_cnt;
  logic [MAX_SF-1:0]           sample_cnt;
  logic [7:0]                  sym_cnt;
  logic                        dir_down;

  logic [PHASE_WIDTH-1:0]      phase_n;
  logic [PHASE_WIDTH-1:0]      f_start;
  logic [PHASE_WIDTH-1:0]      f_step;
  logic [3:0]                  sf_eff;
  logic [MAX_SF-1:0]           last_cnt;
  logic                        ctrl_wr, start, abort, launch;
  logic                        tick, sym_end, last_sym, dir_next, mode_down;

  function automatic logic [PHASE_WIDTH-1:0] freq_init(input logic down,
                                                       input logic [PHASE_WIDTH-1:0] f0);
    return down ? -f0 : f0;
  endfunction

  assign f_start   = PHASE_WIDTH'(f_start_q);
  assign f_step    = PHASE_WIDTH'(f_step_q);
  assign ctrl_wr   = i_cfg_we && (i_cfg_addr == 4'h0);
  assign start     = ctrl_wr && i_cfg_data[0];
  assign abort     = ctrl_wr && i_cfg_data[1];
  assign launch    = start && !abort && (state != S_RUN);
  assign mode_down = (mode_q == 2'd1);
  assign tick      = (div_cnt == div_q);
  assign sym_end   = tick && (sample_cnt == last_cnt);
  assign last_sym  = (nsym_q != 8'd0) && (sym_cnt == nsym_q - 8'd1);
  assign dir_next  = (mode_q == 2'd2) ? ~dir_down : dir_down;
  assign phase_n   = phase_q + freq_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sf_eff = sf_q;
    if (sf_q < SF_MIN)      sf_eff = SF_MIN;
    else if (sf_q > SF_MAX) sf_eff = SF_MAX;
    last_cnt = '0;
    for (int i = 0; i < MAX_SF; i++) begin
      if (i < int'(sf_eff)) last_cnt[i] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      sf_q       <= '0;
      div_q      <= '0;
      nsym_q     <= '0;
      f_start_q  <= '0;
      f_step_q   <= '0;
      phase_q    <= '0;
      freq_q     <= '0;
      div_cnt    <= '0;
      sample_cnt <= '0;
      sym_cnt    <= '0;
      dir_down   <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_done_n   <= 1'b1;
    end else begin
      o_valid <= 1'b0;

      // Configuration is frozen while a sweep runs so a sequence is never torn.
      if (i_cfg_we && state != S_RUN) begin
        case (i_cfg_addr)
          4'h1:                      mode_q <= i_cfg_data[1:0];
          4'h2:                      sf_q   <= i_cfg_data[3:0];
          4'h3:                      div_q  <= DIVIDER_BITWIDTH'(i_cfg_data);
          4'h4:                      nsym_q <= i_cfg_data;
          4'h8, 4'h9, 4'hA, 4'hB:    f_start_q[{i_cfg_addr[1:0], 3'b000} +: 8] <= i_cfg_data;
          4'hC, 4'hD, 4'hE, 4'hF:    f_step_q[{i_cfg_addr[1:0], 3'b000} +: 8]  <= i_cfg_data;
          default: ;
        endcase
      end

      if (launch) begin
        state      <= S_RUN;
        phase_q    <= '0;
        sample_cnt <= '0;
        sym_cnt    <= '0;
        div_cnt    <= '0;
        dir_down   <= mode_down;
        freq_q     <= freq_init(mode_down, f_start);
        o_busy     <= 1'b1;
        o_done_n   <= 1'b1;
      end else if (abort) begin
        // Abort outranks a coinciding sample tick, so o_data keeps its value.
        state    <= S_IDLE;
        o_busy   <= 1'b0;
        o_done_n <= 1'b1;
      end else if (state == S_RUN) begin
        if (tick) begin
          div_cnt <= '0;
          phase_q <= phase_n;
          o_data  <= phase_n[PHASE_WIDTH-1 -: OUT_WIDTH];
          o_valid <= 1'b1;
          if (sym_end) begin
            // Phase is deliberately not reset: it stays continuous across symbols.
            sample_cnt <= '0;
            sym_cnt    <= sym_cnt + 8'd1;
            dir_down   <= dir_next;
            freq_q     <= freq_init(dir_next, f_start);
            if (last_sym) begin
              state    <= S_DONE;
              o_busy   <= 1'b0;
              o_done_n <= 1'b0;
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
            freq_q     <= dir_down ? freq_q - f_step : freq_q + f_step;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// Directed testbench for chirp_sweep_gen: each task drives one scenario and
// compares outputs against hand-computed values or a closed-form chirp model.
module tb_chirp_sweep_gen;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cfg_we = 1'b0;
  logic [3:0] i_cfg_addr = 4'h0;
  logic [7:0] i_cfg_data = 8'h00;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_done_n;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] samp[$];
  logic [7:0] exp_q[$];
  int         when_q[$];
  int         done_cyc;

  chirp_sweep_gen dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_cfg_we  (i_cfg_we),
    .i_cfg_addr(i_cfg_addr),
    .i_cfg_data(i_cfg_data),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_done_n  (o_done_n)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Phase after k samples of a linear chirp from phase 0: k*f0 + st*k(k-1)/2, negated for down.
  function automatic logic [31:0] chirp_phase(input int k, input logic [31:0] f0,
                                              input logic [31:0] st, input bit down);
    logic [63:0] tri_n, p;
    tri_n = 64'(k) * 64'(k - 1) / 64'd2;
    p = 64'(k) * {32'd0, f0} + tri_n * {32'd0, st};
    if (down) p = -p;
    return p[31:0];
  endfunction

  task automatic build_exp(input int n, input logic [31:0] f0, input logic [31:0] st,
                           input bit down, input bit alt);
    logic [31:0] p;
    exp_q.delete();
    for (int j = 1; j <= n; j++) begin
      if (alt && j > 32) p = chirp_phase(32, f0, st, 1'b0) + chirp_phase(j - 32, f0, st, 1'b1);
      else               p = chirp_phase(j, f0, st, down);
      exp_q.push_back(p[31:24]);
    end
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= samp.size()) return i;
      if (samp[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge i_clk);
    i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_data = d;
    @(negedge i_clk);
    i_cfg_we = 1'b0; i_cfg_addr = 4'h0; i_cfg_data = 8'h00;
  endtask

  task automatic wr32(input logic [3:0] base, input logic [31:0] v);
    for (int b = 0; b < 4; b++) wr(base + 4'(b), v[8*b +: 8]);
  endtask

  task automatic cfg(input logic [7:0] mode, input logic [7:0] sf, input logic [7:0] div,
                     input logic [7:0] nsym, input logic [31:0] f0, input logic [31:0] st);
    wr(4'h1, mode); wr(4'h2, sf); wr(4'h3, div); wr(4'h4, nsym);
    wr32(4'h8, f0); wr32(4'hC, st);
  endtask

  // Cycle c of a capture is the cycle T+c after the edge T that sampled the start write.
  task automatic capture(input int max_cycles);
    samp.delete(); when_q.delete(); done_cyc = -1;
    for (int c = 1; c <= max_cycles; c++) begin
      if (o_valid) begin samp.push_back(o_data); when_q.push_back(c); end
      if (!o_done_n) begin done_cyc = c; break; end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    tests_run++;
    if ({o_data, o_valid, o_busy, o_done_n} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got data=%h valid=%b busy=%b done_n=%b, expected 00 0 0 1",
               o_data, o_valid, o_busy, o_done_n);
    end
  endtask

  task automatic test_up_basic();
    logic [7:0] first5 [5];
    first5 = '{8'h00, 8'h01, 8'h03, 8'h06, 8'h0A};
    cfg(8'd0, 8'd5, 8'd0, 8'd1, 32'h0, 32'h0100_0000);
    wr(4'h0, 8'h01);
    tests_run++;
    if (o_busy !== 1'b1) begin
      tests_failed++; $display("FAIL up_busy_t1: got %b expected 1", o_busy);
    end
    capture(200);
    tests_run++;
    if (samp.size() !== 32) begin
      tests_failed++; $display("FAIL up_count: got %0d expected 32", samp.size());
    end
    tests_run++;
    if (when_q.size() == 0 || when_q[0] !== 2) begin
      tests_failed++; $display("FAIL up_first_latency: got %0d expected 2",
                               when_q.size() ? when_q[0] : -1);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= samp.size() || samp[i] !== first5[i]) begin
        tests_failed++; $display("FAIL up_sample%0d: got %h expected %h", i,
                                 (i < samp.size()) ? samp[i] : 8'hxx, first5[i]);
      end
    end
    tests_run++;
    if (samp.size() != 32 || samp[31] !== 8'hF0) begin
      tests_failed++; $display("FAIL up_last_sample: got %h expected F0",
                               samp.size() ? samp[samp.size()-1] : 8'hxx);
    end
    tests_run++;
    if (when_q.size() != 32 || done_cyc !== when_q[31] || o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL up_done_with_last: done_cyc=%0d busy=%b expected done on last pulse, busy 0",
                               done_cyc, o_busy);
    end
    repeat (5) @(negedge i_clk);
    tests_run++;
    if (o_done_n !== 1'b0 || o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL up_done_hold: got done_n=%b valid=%b expected 0 0", o_done_n, o_valid);
    end
  endtask

  task automatic test_divider();
    int bad, idx;
    wr(4'h3, 8'd3);
    wr(4'h0, 8'h01);
    capture(400);
    tests_run++;
    if (when_q.size() == 0 || when_q[0] !== 5) begin
      tests_failed++; $display("FAIL div_first_latency: got %0d expected 5", when_q.size() ? when_q[0] : -1);
    end
    bad = 0;
    for (int i = 1; i < when_q.size(); i++) if (when_q[i] - when_q[i-1] != 4) bad++;
    tests_run++;
    if (bad !== 0 || when_q.size() !== 32) begin
      tests_failed++; $display("FAIL div_period: got %0d bad gaps over %0d pulses, expected 0 over 32", bad, when_q.size());
    end
    build_exp(32, 32'h0, 32'h0100_0000, 1'b0, 1'b0);
    idx = first_diff();
    tests_run++;
    if (idx !== -1) begin
      tests_failed++; $display("FAIL div_sequence: sample %0d got %h expected %h", idx,
                               (idx < samp.size()) ? samp[idx] : 8'hxx, exp_q[idx]);
    end
  endtask

  task automatic test_down_alt();
    int idx;
    cfg(8'd1, 8'd5, 8'd0, 8'd1, 32'h1000_0000, 32'h0010_0000);
    wr(4'h0, 8'h01);
    capture(200);
    tests_run++;
    if (samp.size() < 2 || samp[0] !== 8'hF0 || samp[1] !== 8'hDF) begin
      tests_failed++; $display("FAIL down_first2: got %h %h expected F0 DF",
                               samp.size() > 0 ? samp[0] : 8'hxx, samp.size() > 1 ? samp[1] : 8'hxx);
    end
    build_exp(32, 32'h1000_0000, 32'h0010_0000, 1'b1, 1'b0);
    idx = first_diff();
    tests_run++;
    if (idx !== -1 || samp.size() !== 32) begin
      tests_failed++; $display("FAIL down_sequence: idx %0d size %0d expected no mismatch over 32", idx, samp.size());
    end
    wr(4'h1, 8'd2); wr(4'h4, 8'd2);
    wr(4'h0, 8'h01);
    capture(300);
    tests_run++;
    if (samp.size() !== 64 || done_cyc === -1) begin
      tests_failed++; $display("FAIL alt_count: got %0d samples done_cyc=%0d expected 64 and done", samp.size(), done_cyc);
    end
    build_exp(64, 32'h1000_0000, 32'h0010_0000, 1'b0, 1'b1);
    idx = first_diff();
    tests_run++;
    if (idx !== -1) begin
      tests_failed++; $display("FAIL alt_sequence: sample %0d got %h expected %h", idx,
                               (idx < samp.size()) ? samp[idx] : 8'hxx, exp_q[idx]);
    end
  endtask

  task automatic test_sf_clamp_continuous();
    cfg(8'd0, 8'd2, 8'd0, 8'd1, 32'h0, 32'h0100_0000);
    wr(4'h0, 8'h01);
    capture(200);
    tests_run++;
    if (samp.size() !== 32 || done_cyc === -1) begin
      tests_failed++; $display("FAIL sf_low_clamp: got %0d samples expected 32", samp.size());
    end
    wr(4'h2, 8'd15);
    wr(4'h0, 8'h01);
    capture(4300);
    tests_run++;
    if (samp.size() !== 4096 || done_cyc === -1) begin
      tests_failed++; $display("FAIL sf_high_clamp: got %0d samples expected 4096", samp.size());
    end
    wr(4'h2, 8'd5); wr(4'h4, 8'd0);
    wr(4'h0, 8'h01);
    capture(6500);
    tests_run++;
    if (done_cyc !== -1 || o_done_n !== 1'b1 || samp.size() !== 6499) begin
      tests_failed++; $display("FAIL continuous: got done_cyc=%0d samples=%0d expected -1 and 6499", done_cyc, samp.size());
    end
    wr(4'h0, 8'h02);
    tests_run++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done_n !== 1'b1) begin
      tests_failed++; $display("FAIL abort_t1: got busy=%b valid=%b done_n=%b expected 0 0 1", o_busy, o_valid, o_done_n);
    end
    capture(10);
    tests_run++;
    if (samp.size() !== 0) begin
      tests_failed++; $display("FAIL abort_quiet: got %0d pulses expected 0", samp.size());
    end
  endtask

  task automatic test_config_lock();
    int idx;
    cfg(8'd0, 8'd5, 8'd0, 8'd1, 32'h0, 32'h0100_0000);
    wr(4'h0, 8'h01);
    fork
      capture(200);
      begin
        repeat (2) @(negedge i_clk);
        wr(4'h2, 8'd6);
        wr32(4'hC, 32'hFFFF_FFFF);
        wr(4'h4, 8'd0);
        wr(4'h0, 8'h01);
      end
    join
    build_exp(32, 32'h0, 32'h0100_0000, 1'b0, 1'b0);
    idx = first_diff();
    tests_run++;
    if (idx !== -1 || samp.size() !== 32 || done_cyc === -1) begin
      tests_failed++; $display("FAIL lock_sequence: idx %0d size %0d expected no mismatch over 32 and done", idx, samp.size());
    end
    wr(4'h0, 8'h01);
    tests_run++;
    if (o_done_n !== 1'b1 || o_busy !== 1'b1) begin
      tests_failed++; $display("FAIL restart_t1: got done_n=%b busy=%b expected 1 1", o_done_n, o_busy);
    end
    capture(200);
    idx = first_diff();
    tests_run++;
    if (idx !== -1 || samp.size() !== 32) begin
      tests_failed++; $display("FAIL restart_sequence: idx %0d size %0d expected no mismatch over 32", idx, samp.size());
    end
  endtask

  task automatic test_start_abort();
    int n, c;
    wr(4'h3, 8'd3);
    wr(4'h0, 8'h01);
    n = 0; c = 0;
    while (n < 3 && c < 100) begin
      @(negedge i_clk); c++;
      if (o_valid) n++;
    end
    tests_run++;
    if (n !== 3) begin
      tests_failed++; $display("FAIL sa_wait: got %0d pulses expected 3", n);
    end
    wr(4'h0, 8'h03);
    tests_run++;
    if (o_busy !== 1'b0 || o_done_n !== 1'b1 || o_data !== 8'h03) begin
      tests_failed++; $display("FAIL start_abort_run: got busy=%b done_n=%b data=%h expected 0 1 03",
                               o_busy, o_done_n, o_data);
    end
    wr(4'h0, 8'h03);
    capture(10);
    tests_run++;
    if (o_busy !== 1'b0 || samp.size() !== 0) begin
      tests_failed++; $display("FAIL start_abort_idle: got busy=%b pulses=%0d expected 0 0", o_busy, samp.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, c;
    cfg(8'd0, 8'd5, 8'd0, 8'd1, 32'h0, 32'h0100_0000);
    wr(4'h0, 8'h01);
    n = 0; c = 0;
    while (n < 10 && c < 100) begin
      @(negedge i_clk); c++;
      if (o_valid) n++;
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    tests_run++;
    if (n !== 10 || {o_data, o_valid, o_busy, o_done_n} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++; $display("FAIL reset_mid: got n=%0d data=%h valid=%b busy=%b done_n=%b expected 10 00 0 0 1",
                               n, o_data, o_valid, o_busy, o_done_n);
    end
    capture(40);
    tests_run++;
    if (samp.size() !== 0 || o_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_quiet: got %0d pulses busy=%b expected 0 0", samp.size(), o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_up_basic();
    test_divider();
    test_down_alt();
    test_sf_clamp_continuous();
    test_config_lock();
    test_start_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/chirp_sweep_gen.md
# chirp_sweep_gen

- Parametrised chirp generator core; replaces the fixed up-chirp engine behind the chip top.
- Adds several features:
  - register-mapped configuration port instead of a hard-wired setup;
  - selectable up, down and alternating sweep modes;
  - programmable spreading factor, sample divider and symbol count;
  - abort.
- Outputs a phase-derived sawtooth sample stream with a per-sample valid strobe and an active-low done flag; the UART front end drives its config port.

## Interface
- PHASE_WIDTH, 32: phase accumulator, frequency and step width.
- OUT_WIDTH, 8: sample width (phase MSBs).
- MAX_SF, 12: largest spreading factor; sample counter is MAX_SF bits.
- DIVIDER_BITWIDTH, 7: sample divider width.
- i_clk  in  1  single clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_cfg_we  in  1  config write strobe (one write per cycle, no backpressure).
- i_cfg_addr  in  4  register address.
- i_cfg_data  in  8  write data.
- o_data  out  OUT_WIDTH  current sample.
- o_valid  out  1  one-cycle pulse per new sample.
- o_busy  out  1  high in RUN.
- o_done_n  out  1  low in DONE.

## Operation
Registers (reset 0), 32-bit fields written LSB byte first:
- 0x0, CTRL: bit0 start, bit1 abort. Self-clearing; not stored.
- 0x1, MODE[1:0]: 0 up, 1 down, 2 alternating (up first), 3 treated as 0.
- 0x2, SF[3:0]: effective SF is clamped to 5..MAX_SF.
- 0x3, DIV: sample period is DIV+1 cycles.
- 0x4, NSYM: 0 means continuous until abort.
- 0x8–0xB, F_START.
- 0xC–0xF, F_STEP.
- Unmapped addresses are ignored.

Writes to 0x1–0xF during RUN are ignored. CTRL is always accepted.

FSM:
- IDLE → RUN on start. On entry: phase=0, sample_cnt=0, sym_cnt=0, div_cnt=0, dir=down if MODE=1 else up, freq loaded for dir.
- RUN, on each sample tick (div_cnt==DIV, then div_cnt←0; otherwise div_cnt++):
  - phase_n = phase + freq (mod 2^PHASE_WIDTH);
  - o_data ← phase_n[PHASE_WIDTH-1 -: OUT_WIDTH]; o_valid ← 1;
  - phase ← phase_n; freq ← freq + F_STEP (up) or freq − F_STEP (down);
  - sample_cnt++.
- Symbol end (tick with sample_cnt == 2^SF−1):
  - sample_cnt←0, sym_cnt++;
  - dir toggles if MODE=2; freq reloads for the new dir;
  - phase is NOT reset, so phase stays continuous.
- Freq load: up → F_START; down → −F_START (two's complement).
- RUN → DONE on symbol end when NSYM≠0 and sym_cnt == NSYM−1.
- DONE → RUN on start, with the same entry actions as from IDLE.
- Abort in RUN or DONE → IDLE.
- Start while in RUN is ignored. Start and abort in the same write: abort wins.
- o_data holds its last value in IDLE and DONE, and on abort.

## Timing
- Reset values: o_data=0, o_valid=0, o_busy=0, o_done_n=1. All internal state cleared; FSM in IDLE.
- Reset mid-RUN returns to IDLE on the next edge. No o_valid pulse follows.
- Start write sampled on edge T:
  - o_busy=1 from T+1;
  - first o_valid at cycle T+2+DIV, then every DIV+1 cycles.
- Last sample of the final symbol: o_valid=1 and o_done_n=0 in the same cycle, o_busy=0 from that cycle.
- o_done_n stays low until a start, an abort or reset.
- Abort written on edge T: o_busy=0 at T+1. No o_valid after T+1, even if a tick coincided with edge T.
- All outputs are registered. There is no combinational path from the config port to the outputs.
- Wrap-around: phase and freq wrap modulo 2^PHASE_WIDTH without saturation.

## Test plan
- **Up chirp, basic sequence:** reset; SF=5, DIV=0, NSYM=1, MODE=0, F_START=0, F_STEP=0x01000000; start.
  - First five o_data: 0x00, 0x01, 0x03, 0x06, 0x0A.
  - Exactly 32 o_valid pulses, first at T+2.
  - o_done_n low on the 32nd pulse.
- **Divider:** same setup with DIV=3.
  - o_valid period is 4 cycles; first pulse at T+5.
  - o_data sequence identical to the previous test.
- **Down and alternating modes:** F_START=0x10000000, F_STEP=0x00100000, SF=5.
  - MODE=1: internal freq starts at 0xF0000000 and decreases.
  - MODE=2 with NSYM=2: direction flips after 32 samples, phase is continuous across the boundary, and 64 samples are produced in total.
- **SF clamp and continuous run:**
  - SF=2 gives symbols of 32 samples.
  - SF=15 gives symbols of 2^MAX_SF samples.
  - NSYM=0: o_done_n stays high after 200 symbols; abort gives o_busy=0 one cycle later.
- **Config locking and start collisions:**
  - Writing SF or F_STEP during RUN does not change the output sequence.
  - Start during RUN is ignored.
  - Start and abort in one write goes to IDLE.
  - Restart from DONE sets o_done_n=1 at T+1 and reproduces the same sequence.
- **Reset mid-symbol:**
  - i_rst high for 1 cycle at sample 10: all outputs return to reset values on the next edge.
  - No further o_valid until a new start.
